// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential PC generation, 1-cycle synchronous IMEM,
// DEPTH-entry fetch queue toward ID, and redirect with wrong-path flush.
module fetch_unit #(
  parameter int unsigned     XLEN            = 32,
  parameter logic [XLEN-1:0] RESET_PC        = '0,
  parameter int unsigned     IMEM_ADDR_WIDTH = 10,
  parameter int unsigned     DEPTH           = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       fetch_en_i,
  input  logic                       redirect_i,
  input  logic [XLEN-1:0]            redirect_pc_i,
  output logic                       imem_req_o,
  output logic [IMEM_ADDR_WIDTH-1:0] imem_addr_o,
  input  logic [XLEN-1:0]            imem_rdata_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [XLEN-1:0]            out_pc_o,
  output logic [XLEN-1:0]            out_instr_o,
  output logic [XLEN-1:0]            out_pc_plus4_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW:0] DepthOcc = (CntW + 1)'(DEPTH);

  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [CntW-1:0] cnt_t;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] pc_inflight_q, pc_inflight_d;
  logic            inflight_q, inflight_d;
  cnt_t            count_q, count_d;
  ptr_t            rd_ptr_q, rd_ptr_d;
  ptr_t            wr_ptr_q, wr_ptr_d;

  logic [XLEN-1:0] pc_mem_q    [DEPTH];
  logic [XLEN-1:0] instr_mem_q [DEPTH];

  logic            issue;
  logic            push;
  logic            pop;
  logic [CntW:0]   occupancy;
  logic [XLEN-1:0] redirect_target;

  // Low two bits of the redirect target are architecturally ignored.
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc_i[1:0];
  assign redirect_target     = {redirect_pc_i[XLEN-1:2], 2'b00};

  // Queue slots are reserved at issue time, so an in-flight response always fits.
  assign occupancy = {1'b0, count_q} + {{CntW{1'b0}}, inflight_q};
  assign issue     = rst_n & fetch_en_i & ~redirect_i & (occupancy < DepthOcc);
  assign push      = inflight_q & ~redirect_i;
  assign pop       = out_valid_o & out_ready_i;

  assign imem_req_o  = issue;
  assign imem_addr_o = fetch_pc_q[IMEM_ADDR_WIDTH+1:2];

  assign out_valid_o    = rst_n & (count_q != '0) & ~redirect_i;
  assign out_pc_o       = pc_mem_q[rd_ptr_q];
  assign out_instr_o    = instr_mem_q[rd_ptr_q];
  assign out_pc_plus4_o = out_pc_o + XLEN'(4);

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    pc_inflight_d = pc_inflight_q;
    inflight_d    = issue;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;

    if (redirect_i) begin
      fetch_pc_d = redirect_target;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (issue) begin
        pc_inflight_d = fetch_pc_q;
        fetch_pc_d    = fetch_pc_q + XLEN'(4);
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + ptr_t'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + ptr_t'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + cnt_t'(1);
        2'b01:   count_d = count_q - cnt_t'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_q    <= RESET_PC;
      pc_inflight_q <= '0;
      inflight_q    <= 1'b0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      pc_inflight_q <= pc_inflight_d;
      inflight_q    <= inflight_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
    end
  end

  // Storage needs no reset: count gates visibility of every entry.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      pc_mem_q[wr_ptr_q]    <= pc_inflight_q;
      instr_mem_q[wr_ptr_q] <= imem_rdata_i;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic, checked every cycle
// against a queue-level model of the fetch stream.
module tb_fetch_unit;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned AW    = 10;
  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RST_PC = 32'hFFFF_FFFC;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fetch_en = 1'b0;
  logic          redirect = 1'b0;
  logic [31:0]   redirect_pc = '0;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rdata = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_pc;
  logic [31:0]   out_instr;
  logic [31:0]   out_pc_plus4;

  int total = 0;
  int bad   = 0;

  // Model: PCs queued for ID, the outstanding request, and the next fetch PC.
  logic [31:0] m_q[$];
  logic [31:0] acc[$];
  logic [31:0] m_fetch_pc = RST_PC;
  bit          m_pend = 1'b0;
  logic [31:0] m_pend_pc = '0;

  fetch_unit #(
    .XLEN(XLEN),
    .RESET_PC(RST_PC),
    .IMEM_ADDR_WIDTH(AW),
    .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .fetch_en_i(fetch_en),
    .redirect_i(redirect),
    .redirect_pc_i(redirect_pc),
    .imem_req_o(imem_req),
    .imem_addr_o(imem_addr),
    .imem_rdata_i(imem_rdata),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_pc_o(out_pc),
    .out_instr_o(out_instr),
    .out_pc_plus4_o(out_pc_plus4)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    return 32'h1000 + 32'(a);
  endfunction

  // Synchronous instruction memory, one cycle of read latency.
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= mem_word(imem_addr);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] acc_head();
    if (acc.size() == 0) return 'x;
    return acc[0];
  endfunction

  // One clock: compare at the falling edge, advance the model, return 1 after the rising edge.
  task automatic step();
    bit          exp_req;
    bit          exp_valid;
    logic [31:0] head;
    @(negedge clk);
    exp_req   = rst_n && fetch_en && !redirect && ((m_q.size() + int'(m_pend)) < DEPTH);
    exp_valid = rst_n && (m_q.size() != 0) && !redirect;
    check("imem_req", 32'(imem_req), 32'(exp_req));
    if (exp_req) check("imem_addr", 32'(imem_addr), 32'(m_fetch_pc[AW+1:2]));
    check("out_valid", 32'(out_valid), 32'(exp_valid));
    if (exp_valid) begin
      head = m_q[0];
      check("out_pc", out_pc, head);
      check("out_instr", out_instr, mem_word(head[AW+1:2]));
      check("out_pc_plus4", out_pc_plus4, head + 32'd4);
    end
    if (!rst_n) begin
      m_q.delete();
      m_pend     = 1'b0;
      m_fetch_pc = RST_PC;
    end else if (redirect) begin
      m_q.delete();
      m_pend     = 1'b0;
      m_fetch_pc = {redirect_pc[31:2], 2'b00};
    end else begin
      if (exp_valid && out_ready) begin
        acc.push_back(m_q[0]);
        void'(m_q.pop_front());
      end
      if (m_pend) m_q.push_back(m_pend_pc);
      m_pend    = exp_req;
      m_pend_pc = m_fetch_pc;
      if (exp_req) m_fetch_pc = m_fetch_pc + 32'd4;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with fetch enabled: no request or output while held.
    rst_n = 1'b0; fetch_en = 1'b1; out_ready = 1'b1;
    repeat (2) step();

    // Streaming from RESET_PC, crossing the 2^32 wrap.
    rst_n = 1'b1;
    acc.delete();
    repeat (10) step();
    check("first_pc", acc_head(), 32'hFFFF_FFFC);
    check("second_pc", (acc.size() > 1) ? acc[1] : 'x, 32'h0000_0000);
    check("third_pc", (acc.size() > 2) ? acc[2] : 'x, 32'h0000_0004);

    // Stall: fetch stops at DEPTH outstanding, then resumes without gaps.
    out_ready = 1'b0;
    repeat (8) step();
    check("stall_no_req", 32'(imem_req), 32'd0);
    out_ready = 1'b1;
    repeat (8) step();

    // Build three queued entries with one in flight, then redirect.
    out_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0200;
    step();
    redirect = 1'b0;
    repeat (4) step();
    check("setup_head_pc", out_pc, 32'h0000_0200);
    check("setup_valid", 32'(out_valid), 32'd1);
    redirect = 1'b1; redirect_pc = 32'h0000_0100;
    #1 check("redir_valid_low", 32'(out_valid), 32'd0);
    step();
    redirect = 1'b0; out_ready = 1'b1;
    #1 check("redir_addr", 32'(imem_addr), 32'h40);
    acc.delete();
    repeat (8) step();
    check("redir_first_pc", acc_head(), 32'h0000_0100);

    // Misaligned redirect target: low bits dropped.
    redirect = 1'b1; redirect_pc = 32'h0000_0102;
    step();
    redirect = 1'b0;
    acc.delete();
    repeat (6) step();
    check("redir_misaligned_pc", acc_head(), 32'h0000_0100);

    // Disable fetch: in-flight response is kept, queue drains.
    fetch_en = 1'b0;
    repeat (8) step();
    check("drain_valid", 32'(out_valid), 32'd0);
    check("drain_req", 32'(imem_req), 32'd0);
    fetch_en = 1'b1;
    repeat (4) step();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      fetch_en    = ($urandom_range(0, 9) != 0);
      out_ready   = ($urandom_range(0, 9) < 7);
      redirect    = ($urandom_range(0, 19) == 0);
      redirect_pc = $urandom;
      rst_n       = ($urandom_range(0, 49) != 0);
      step();
    end
    rst_n = 1'b1; redirect = 1'b0; fetch_en = 1'b1;

    // Fill the queue, then reset mid-operation.
    out_ready = 1'b0;
    repeat (8) step();
    rst_n = 1'b0;
    #1 check("rst_valid_low", 32'(out_valid), 32'd0);
    check("rst_req_low", 32'(imem_req), 32'd0);
    step();
    rst_n = 1'b1; out_ready = 1'b1;
    #1 check("post_rst_req", 32'(imem_req), 32'd1);
    check("post_rst_addr", 32'(imem_addr), 32'h3FF);
    check("post_rst_valid", 32'(out_valid), 32'd0);
    repeat (6) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Parametrised next-generation instruction fetch stage.
- Generates sequential PCs and drives a synchronous instruction memory with fixed 1-cycle read latency.
- Buffers returned instructions in a DEPTH-entry fetch queue with a valid/ready handshake toward ID.
- Supports redirect (branch/jump/trap) with flush of queued and in-flight wrong-path fetches.

Parameters:
- XLEN, 32, width of PC and instruction word.
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- IMEM_ADDR_WIDTH, 10, word-address width of instruction memory.
- DEPTH, 4, fetch queue entries (power of two, >=2).

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, synchronous, active-low.
- fetch_en_i  input  1  allow new fetch requests.
- redirect_i  input  1  redirect request (branch taken, jump, trap).
- redirect_pc_i  input  XLEN  redirect target.
- imem_req_o  output  1  memory read request this cycle.
- imem_addr_o  output  IMEM_ADDR_WIDTH  word address = fetch_pc[IMEM_ADDR_WIDTH+1:2].
- imem_rdata_i  input  XLEN  read data, valid the cycle after imem_req_o.
- out_valid_o  output  1  queue head valid.
- out_ready_i  input  1  ID accepts head.
- out_pc_o  output  XLEN  head PC.
- out_instr_o  output  XLEN  head instruction.
- out_pc_plus4_o  output  XLEN  head PC + 4.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-low. While rst_n=0 at a clk edge:
  - fetch_pc <= RESET_PC; queue count, read pointer and write pointer <= 0; inflight <= 0.
  - imem_req_o and out_valid_o are 0 during any cycle with rst_n=0.
  - Reset mid-operation discards all queued and in-flight data with no residual output.
- Request issue: imem_req_o = fetch_en_i & !redirect_i & (count + inflight < DEPTH). On issue:
  - inflight <= 1, pc_inflight <= fetch_pc, fetch_pc <= fetch_pc + 4.
  - Otherwise inflight <= 0.
  - At most one request per cycle; back-to-back issue gives one instruction per cycle.
- Response: in the cycle after issue, {pc_inflight, imem_rdata_i} is written at the queue tail, unless redirect_i is 1 that cycle, in which case it is dropped.
  - Space is reserved at issue, so the queue never overflows.
- Output: head is combinational from queue storage.
  - out_valid_o = (count != 0) & !redirect_i.
  - Pop when out_valid_o & out_ready_i.
  - out_pc_plus4_o = out_pc_o + 4, truncated to XLEN.
  - Push and pop in the same cycle leave count unchanged. Pointers wrap modulo DEPTH.
- Minimum latency: request issued in cycle t, data written at the end of t+1, out_valid_o=1 in t+2.
- Redirect (priority over everything but reset). In cycle t with redirect_i=1:
  - Queue cleared (count <= 0, pointers <= 0).
  - Response arriving in t is dropped; no request is issued in t.
  - fetch_pc <= {redirect_pc_i[XLEN-1:2], 2'b00} (low bits ignored).
  - First request to the target is in t+1; the target instruction is visible at the earliest in t+3.
- Stall: out_ready_i=0 holds the head stable (pc, instr, valid). Fetch continues until count + inflight = DEPTH, then stops.
- fetch_en_i=0: no new requests; an in-flight response is still written; the queue drains normally. Re-enable resumes at the current fetch_pc.
- PC arithmetic: modulo 2^XLEN. 0xFFFF_FFFC + 4 = 0x0000_0000.

Test Plan:
- Reset release, fetch_en=1, ready=1, imem word i = 0x1000+i → first out_valid 2 cycles after the first request; pc 0,4,8,… with instr 0x1000,0x1001,0x1002 and pc_plus4 4,8,12, one per cycle.
- ready=0 from start → exactly DEPTH=4 requests (addr 0..3), then imem_req_o=0. Head stays pc=0. Release ready → pcs 0,4,8,12,16… with no gap, loss or duplicate.
- With 3 queued entries and 1 in flight, pulse redirect_i with pc=0x100 → out_valid_o=0 in the redirect cycle, imem_addr_o=0x40 next cycle, next accepted pc=0x100, no stale pc seen.
- Redirect to 0x102 → fetch at word 0x40, out_pc_o=0x100.
- fetch_en=0 with a request in flight → that entry is queued, no further requests, queue drains to out_valid_o=0.
- RESET_PC=0xFFFF_FFFC → out_pc 0xFFFF_FFFC with pc_plus4 0x0, then pc 0x0. Assert rst_n=0 with a full queue → the next cycle has out_valid_o=0 and the first request is at the RESET_PC word address.
